// File: rtl/sortmax_pkg.sv
// Shared definitions for the sortmax observation slice: state encoding,
// controller output width and MISR feedback taps (x^20 + x^17 + 1).
package sortmax_pkg;

  localparam int SORTMAX_YW = 20;
  localparam int MISR_TAP_A = 19;
  localparam int MISR_TAP_B = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_COMPARE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sortmax_sig_monitor_if.sv
// Bus between the sortmax output stage and its signature monitor.
// The master drives run control and data; the slave reports status.
interface sortmax_sig_monitor_if
  import sortmax_pkg::*;
#(
  parameter int WIDTH = SORTMAX_YW
);

  logic             start;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] golden;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] sig;
  logic [15:0]      sample_cnt;
  logic             zrun_alarm;

  modport master (
    output start, y, golden,
    input  busy, done, pass, sig, sample_cnt, zrun_alarm
  );

  modport slave (
    input  start, y, golden,
    output busy, done, pass, sig, sample_cnt, zrun_alarm
  );

endinterface

// File: rtl/sortmax_misr.sv
// Multiple-input signature register: shift left with two-tap feedback,
// XOR in the parallel input. Synchronous clear has priority over enable.
module sortmax_misr
  import sortmax_pkg::*;
#(
  parameter int WIDTH = SORTMAX_YW,
  parameter int TAP_A = MISR_TAP_A,
  parameter int TAP_B = MISR_TAP_B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_sig
);

  logic [WIDTH-1:0] r_sig;
  logic             w_fb;

  assign w_fb  = r_sig[TAP_A] ^ r_sig[TAP_B];
  assign o_sig = r_sig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_sig <= '0;
    else if (i_clr) r_sig <= '0;
    else if (i_en)  r_sig <= {r_sig[WIDTH-2:0], w_fb} ^ i_d;
  end

endmodule

// File: rtl/sortmax_sig_monitor.sv
// Windowed MISR capture of the sortmax output vector with golden compare
// and a sticky alarm for runs of all-zero output vectors.
module sortmax_sig_monitor
  import sortmax_pkg::*;
#(
  parameter int WIDTH    = SORTMAX_YW,
  parameter int WINDOW   = 64,
  parameter int ZRUN_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sortmax_sig_monitor_if.slave mon
);

  localparam int          ZW   = $clog2(ZRUN_MAX + 1);
  localparam logic [15:0] LAST = 16'(WINDOW - 1);

  state_t           r_state, w_next;
  logic             w_clr, w_cap;
  logic [15:0]      r_cnt;
  logic [ZW-1:0]    r_zcnt;
  logic             r_alarm, r_pass;
  logic [WIDTH-1:0] w_sig;

  assign w_cap = (r_state == ST_CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (mon.start) begin
        w_next = ST_CAPTURE;
        w_clr  = 1'b1;
      end
      ST_CAPTURE: if (r_cnt == LAST) w_next = ST_COMPARE;
      ST_COMPARE: w_next = ST_DONE;
      default:    w_next = ST_IDLE;
    endcase
  end

  sortmax_misr #(
    .WIDTH (WIDTH),
    .TAP_A (MISR_TAP_A),
    .TAP_B (MISR_TAP_B)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_cap),
    .i_d   (mon.y),
    .o_sig (w_sig)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (w_clr) r_cnt <= '0;
    else if (w_cap) r_cnt <= r_cnt + 16'd1;
  end

  // Alarm sets on the edge the run length reaches ZRUN_MAX, including the last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zcnt  <= '0;
      r_alarm <= 1'b0;
    end else if (w_clr) begin
      r_zcnt  <= '0;
      r_alarm <= 1'b0;
    end else if (w_cap) begin
      if (mon.y == '0) begin
        if (r_zcnt != ZW'(ZRUN_MAX)) r_zcnt <= r_zcnt + ZW'(1);
        if (r_zcnt >= ZW'(ZRUN_MAX - 1)) r_alarm <= 1'b1;
      end else begin
        r_zcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_pass <= 1'b0;
    else if (w_clr)                r_pass <= 1'b0;
    else if (r_state == ST_COMPARE) r_pass <= (w_sig == mon.golden);
  end

  assign mon.busy       = (r_state == ST_CAPTURE) || (r_state == ST_COMPARE);
  assign mon.done       = (r_state == ST_DONE);
  assign mon.pass       = r_pass;
  assign mon.sig        = w_sig;
  assign mon.sample_cnt = r_cnt;
  assign mon.zrun_alarm = r_alarm;

endmodule

// File: tb/tb_sortmax_sig_monitor.sv
// Directed checks of sortmax_sig_monitor at WINDOW = 2, 16 and 64.
module tb_sortmax_sig_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sortmax_sig_monitor_if #(.WIDTH(20)) bus2  ();
  sortmax_sig_monitor_if #(.WIDTH(20)) bus16 ();
  sortmax_sig_monitor_if #(.WIDTH(20)) bus64 ();

  sortmax_sig_monitor #(.WIDTH(20), .WINDOW(2),  .ZRUN_MAX(8)) dut2  (.clk(clk), .rst(rst), .mon(bus2));
  sortmax_sig_monitor #(.WIDTH(20), .WINDOW(16), .ZRUN_MAX(8)) dut16 (.clk(clk), .rst(rst), .mon(bus16));
  sortmax_sig_monitor #(.WIDTH(20))                            dut64 (.clk(clk), .rst(rst), .mon(bus64));

  typedef struct packed {
    logic [19:0] y0;
    logic [19:0] y1;
    logic [19:0] golden;
    logic [19:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [19:0] misr_step(input logic [19:0] s, input logic [19:0] d);
    return {s[18:0], s[19] ^ s[16]} ^ d;
  endfunction

  // Stand-in controller response: s1 output while held there, then a walking pattern with idle gaps.
  function automatic logic [19:0] ctl_y(input int step);
    logic [19:0] one;
    one = 20'h00001;
    if (step < 3)          return one;
    else if (step % 5 == 0) return 20'h00000;
    else                   return (one << (step % 20)) | 20'h00400;
  endfunction

  function automatic logic [19:0] run_y(input int i);
    return 20'(i * 32'h0F0F3) ^ 20'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [19:0] g;
  logic [19:0] y_v;

  initial begin
    bus2.start  = 1'b0; bus2.y  = '0; bus2.golden  = '0;
    bus16.start = 1'b0; bus16.y = '0; bus16.golden = '0;
    bus64.start = 1'b0; bus64.y = '0; bus64.golden = '0;

    vecs[0] = '{20'h00001, 20'h00000, 20'h00002, 20'h00002, 1'b1};
    vecs[1] = '{20'h00001, 20'h00000, 20'h00003, 20'h00002, 1'b0};
    vecs[2] = '{20'h80000, 20'h00000, 20'h00001, 20'h00001, 1'b1};
    vecs[3] = '{20'h10000, 20'h00005, 20'h20004, 20'h20004, 1'b1};
    vecs[4] = '{20'h90000, 20'hFFFFF, 20'h00000, 20'hDFFFF, 1'b0};
    vecs[5] = '{20'hABCDE, 20'h12345, 20'h45AF8, 20'h45AF8, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus64.busy), 32'd0);
    chk("rst_done", 32'(bus64.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus2.busy), 32'd0);
    chk("idle_done", 32'(bus2.done), 32'd0);
    chk("idle_pass", 32'(bus2.pass), 32'd0);
    chk("idle_sig",  32'(bus2.sig),  32'd0);
    chk("idle_cnt",  32'(bus2.sample_cnt), 32'd0);
    chk("idle_alarm", 32'(bus2.zrun_alarm), 32'd0);

    // WINDOW=2 vector table, each run restarting from DONE after the first
    for (int v = 0; v < 6; v++) begin
      bus2.golden = vecs[v].golden;
      bus2.start  = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      bus2.y     = vecs[v].y0;
      chk("w2_busy_after_start", 32'(bus2.busy), 32'd1);
      chk("w2_cnt_after_start",  32'(bus2.sample_cnt), 32'd0);
      chk("w2_pass_cleared",     32'(bus2.pass), 32'd0);
      @(negedge clk);
      bus2.y = vecs[v].y1;
      chk("w2_cnt1", 32'(bus2.sample_cnt), 32'd1);
      @(negedge clk);
      chk("w2_compare_busy", 32'(bus2.busy), 32'd1);
      chk("w2_compare_done", 32'(bus2.done), 32'd0);
      chk("w2_cnt2", 32'(bus2.sample_cnt), 32'd2);
      @(negedge clk);
      chk("w2_done", 32'(bus2.done), 32'd1);
      chk("w2_busy_low", 32'(bus2.busy), 32'd0);
      chk("w2_sig",  32'(bus2.sig),  32'(vecs[v].exp_sig));
      chk("w2_pass", 32'(bus2.pass), 32'(vecs[v].exp_pass));
      @(negedge clk);
      chk("w2_done_held", 32'(bus2.done), 32'd1);
    end

    // WINDOW=64 all-zero run: alarm from the 8th sample, signature stays zero
    bus64.golden = '0;
    bus64.start  = 1'b1;
    @(negedge clk);
    bus64.start = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      bus64.y = '0;
      @(negedge clk);
      chk("z_alarm", 32'(bus64.zrun_alarm), (i >= 8) ? 32'd1 : 32'd0);
      chk("z_cnt",   32'(bus64.sample_cnt), 32'(i));
    end
    @(negedge clk);
    chk("z_done",  32'(bus64.done), 32'd1);
    chk("z_pass",  32'(bus64.pass), 32'd1);
    chk("z_cnt64", 32'(bus64.sample_cnt), 32'd64);
    chk("z_alarm_held", 32'(bus64.zrun_alarm), 32'd1);

    // Zero-run broken at 7: start from DONE clears the sticky alarm
    g = '0;
    for (int i = 1; i <= 64; i++) begin
      y_v = (i == 8) ? 20'h00100 : ((i <= 15) ? 20'h00000 : 20'h00001);
      g = misr_step(g, y_v);
    end
    bus64.golden = g;
    bus64.start  = 1'b1;
    @(negedge clk);
    bus64.start = 1'b0;
    chk("brk_alarm_cleared", 32'(bus64.zrun_alarm), 32'd0);
    chk("brk_done_cleared",  32'(bus64.done), 32'd0);
    chk("brk_cnt_cleared",   32'(bus64.sample_cnt), 32'd0);
    for (int i = 1; i <= 64; i++) begin
      bus64.y = (i == 8) ? 20'h00100 : ((i <= 15) ? 20'h00000 : 20'h00001);
      @(negedge clk);
      chk("brk_alarm", 32'(bus64.zrun_alarm), 32'd0);
    end
    @(negedge clk);
    chk("brk_done", 32'(bus64.done), 32'd1);
    chk("brk_sig",  32'(bus64.sig),  32'(g));
    chk("brk_pass", 32'(bus64.pass), 32'd1);

    // Asynchronous reset mid-run, then a fresh full run
    bus64.start = 1'b1;
    @(negedge clk);
    bus64.start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus64.y = 20'(i * 32'h11111);
      @(negedge clk);
    end
    chk("pre_rst_cnt", 32'(bus64.sample_cnt), 32'd10);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  32'(bus64.busy), 32'd0);
    chk("arst_done",  32'(bus64.done), 32'd0);
    chk("arst_pass",  32'(bus64.pass), 32'd0);
    chk("arst_sig",   32'(bus64.sig),  32'd0);
    chk("arst_cnt",   32'(bus64.sample_cnt), 32'd0);
    chk("arst_alarm", 32'(bus64.zrun_alarm), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(bus64.busy), 32'd0);
    g = '0;
    for (int i = 1; i <= 64; i++) g = misr_step(g, run_y(i));
    bus64.golden = g;
    bus64.start  = 1'b1;
    @(negedge clk);
    bus64.start = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      bus64.y = run_y(i);
      @(negedge clk);
    end
    chk("fresh_busy_compare", 32'(bus64.busy), 32'd1);
    @(negedge clk);
    chk("fresh_done", 32'(bus64.done), 32'd1);
    chk("fresh_cnt",  32'(bus64.sample_cnt), 32'd64);
    chk("fresh_sig",  32'(bus64.sig),  32'(g));
    chk("fresh_pass", 32'(bus64.pass), 32'd1);

    // WINDOW=16 on controller-style data; start pulses in CAPTURE and COMPARE ignored
    g = '0;
    for (int i = 0; i < 16; i++) g = misr_step(g, ctl_y(i));
    bus16.golden = g;
    bus16.start  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bus16.start = (i == 5 || i == 9);
      bus16.y     = ctl_y(i);
      @(negedge clk);
    end
    bus16.start = 1'b1;
    chk("w16_compare_busy", 32'(bus16.busy), 32'd1);
    chk("w16_compare_cnt",  32'(bus16.sample_cnt), 32'd16);
    @(negedge clk);
    bus16.start = 1'b0;
    chk("w16_done", 32'(bus16.done), 32'd1);
    chk("w16_busy", 32'(bus16.busy), 32'd0);
    chk("w16_sig",  32'(bus16.sig),  32'(g));
    chk("w16_pass", 32'(bus16.pass), 32'd1);
    @(negedge clk);
    chk("w16_done_held", 32'(bus16.done), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sortmax_sig_monitor.md
# sortmax_sig_monitor

Downstream observation stage for the `sortmax` controller benchmark. It samples the controller's 20-bit output vector (y1..y20, packed y1 = bit 0) over a programmable window and compacts it into a MISR signature. At the end of the window it compares the signature against a golden value and raises pass/done. Independently, it flags runs of all-zero output vectors, the signature of suppressed-output payloads.

## Interface
- `WIDTH`, default 20 — output-vector and signature width.
- `WINDOW`, default 64 — samples absorbed per run; legal range 1..65535.
- `ZRUN_MAX`, default 8 — consecutive all-zero samples that trigger the alarm; minimum 1.
- `clk`  in  1 — sampling clock; rising edge (upstream FSM updates on falling edge, so `y` is stable).
- `rst`  in  1 — reset, asynchronous, active-high.
- `start`  in  1 — begin a run; honoured only in IDLE or DONE.
- `y`  in  WIDTH — controller output vector.
- `golden`  in  WIDTH — expected signature; must be stable from `start` until `done`.
- `busy`  out  1 — high in CAPTURE and COMPARE.
- `done`  out  1 — level, high in DONE.
- `pass`  out  1 — registered compare result; valid while `done`.
- `sig`  out  WIDTH — current MISR contents.
- `sample_cnt`  out  16 — samples absorbed in the current run.
- `zrun_alarm`  out  1 — sticky zero-run flag; cleared on `start`.

## Operation
- States: IDLE, CAPTURE, COMPARE, DONE.
- IDLE/DONE + `start`=1 → CAPTURE:
  - clear `sig`, `sample_cnt`, zero-run counter, `zrun_alarm` and `pass`.
  - The `start` edge itself absorbs no sample.
- CAPTURE, each edge:
  - `sig` ← {sig[WIDTH-2:0], fb} XOR `y`, where fb = sig[19] XOR sig[16] (x^20+x^17+1).
  - `sample_cnt` +1.
  - At the edge that absorbs sample number WINDOW → COMPARE.
  - `start` is ignored in this state.
- Zero-run counter (CAPTURE only):
  - increments when `y`==0, otherwise clears; saturates at ZRUN_MAX.
  - `zrun_alarm` sets on the edge the counter reaches ZRUN_MAX and stays set until the next `start` or `rst`.
- COMPARE → DONE after one edge; `pass` ← (sig == golden).
  - `sig` is frozen from COMPARE onward.
- DONE holds `done`, `pass`, `sig`, `sample_cnt` until `start` or `rst`.
  - `start` in DONE restarts directly into CAPTURE.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `pass`=0, `sig`=0, `sample_cnt`=0, `zrun_alarm`=0.
- `start` sampled at edge k:
  - samples are absorbed at edges k+1 .. k+WINDOW;
  - COMPARE is active during the cycle after edge k+WINDOW;
  - `done`=1 and `pass` are valid after edge k+WINDOW+1.
- `busy` rises after edge k and falls after edge k+WINDOW+1, in the same edge that raises `done`.
- Simultaneous events:
  - all-zero `y` on the final sample still updates the zero-run counter and alarm in that edge;
  - `start` during COMPARE is ignored.
- `rst` asserted mid-run immediately forces all outputs to their reset values. No partial result is retained.
- `sample_cnt` never wraps: the WINDOW ≤ 65535 limit guarantees this.

## Structure
- Shared package `sortmax_pkg` holds:
  - the state enum;
  - `SORTMAX_YW` = 20;
  - MISR tap constants (19, 16).
- One sub-module, `sortmax_misr`: parameterised MISR register with synchronous clear, enable and async reset. The top module keeps the FSM, counters and compare.

## Test plan
- WINDOW=2, `y` = 0x00001 then 0x00000, golden=0x00002 → `sig`=0x00002, `pass`=1, `done` high 3 edges after `start`.
- Same stimulus with golden=0x00003 → `done`=1, `pass`=0, `sig`=0x00002.
- Default WINDOW=64, `y`=0 throughout, golden=0 → `zrun_alarm` rises on the 8th sample edge, then `pass`=1, `sample_cnt`=64.
- Zero-run break: 7 zeros, one 0x00100, 7 zeros → `zrun_alarm` stays 0.
- `rst` pulsed after 10 samples of a 64-sample run → all outputs 0 asynchronously; next `start` yields a full fresh 64-sample run.
- Drive the behavioural `sortmax` model (negedge clk) from reset with `x5=1, x3=0, x1=1`, `x2=0` until the controller leaves s1, then hold all x inputs low → signature matches the model-computed golden for WINDOW=16; `start` pulses during CAPTURE have no effect.
